// File: rtl/gdsp_pkg.sv
// gdsp_pkg
//   Shared numeric types and sizing for the DSP blocks.
//   sample_t : signed Q1.11 sample / MAC operand
//   coeff_t  : signed Q1.11 filter coefficient
//   accum_t  : signed MAC accumulator result (Q.22 before rounding)
package gdsp_pkg;

    localparam int NUM_TAPS    = 33;
    localparam int DATA_WIDTH  = 12;
    localparam int FRAC_BITS   = 11;
    localparam int ACCUM_WIDTH = 30;

    // Width of the coefficient ROM address bus.
    localparam int COEFF_ADDR_WIDTH = 6;

    typedef logic signed [DATA_WIDTH-1:0]  sample_t;
    typedef logic signed [DATA_WIDTH-1:0]  coeff_t;
    typedef logic signed [ACCUM_WIDTH-1:0] accum_t;

endpackage

// File: rtl/rrc_mac_seq_if.sv
// rrc_mac_seq_if
//   Bundles every non-clock signal of rrc_mac_seq.
//   slave  : the sequencer side (rrc_mac_seq)
//   master : the environment side (sample source, coefficient ROM / MAC, sink)
//
//   Handshakes (in_valid/in_ready, out_valid/out_ready): a transfer happens
//   on a rising clock edge where both valid and ready are high. The sender
//   holds valid and its payload stable until that edge; ready may depend on
//   the receiver's state but never on valid of the same cycle.
//   acc_valid is a one-cycle strobe with no back-pressure.
interface rrc_mac_seq_if;
    import gdsp_pkg::*;

    // input sample handshake
    logic                        in_valid;
    logic                        in_ready;
    sample_t                     in_sample;
    // coefficient ROM / MAC drive
    logic [COEFF_ADDR_WIDTH-1:0] coeff_addr;
    sample_t                     mul_a;
    logic                        mac_en;
    logic                        mac_first;
    logic                        mac_last;
    // MAC result return
    logic                        acc_valid;
    accum_t                      acc_data;
    // output sample handshake
    logic                        out_valid;
    logic                        out_ready;
    sample_t                     out_data;
    logic                        out_sat;
    // status
    logic                        busy;

    modport slave (
        input  in_valid, in_sample, acc_valid, acc_data, out_ready,
        output in_ready, coeff_addr, mul_a, mac_en, mac_first, mac_last,
               out_valid, out_data, out_sat, busy
    );

    modport master (
        output in_valid, in_sample, acc_valid, acc_data, out_ready,
        input  in_ready, coeff_addr, mul_a, mac_en, mac_first, mac_last,
               out_valid, out_data, out_sat, busy
    );

endinterface

// File: rtl/rrc_round_sat.sv
// rrc_round_sat
//   Combinational round-half-up and clip of a MAC result back to Q1.11.
//   acc_i  : accumulator value with FRAC_BITS extra fractional bits
//   data_o : rounded, clamped sample
//   sat_o  : high when the rounded value fell outside the sample range
module rrc_round_sat
    import gdsp_pkg::*;
(
    input  accum_t  acc_i,
    output sample_t data_o,
    output logic    sat_o
);

    // One guard bit so adding the rounding constant cannot overflow.
    localparam int EXT_W = ACCUM_WIDTH + 1;

    localparam logic signed [EXT_W-1:0] HALF_LSB = EXT_W'(1) <<< (FRAC_BITS - 1);
    localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [EXT_W-1:0] biased;
    logic signed [EXT_W-1:0] shifted;

    always_comb begin
        biased  = $signed({acc_i[ACCUM_WIDTH-1], acc_i}) + HALF_LSB;
        shifted = biased >>> FRAC_BITS;
        data_o  = shifted[DATA_WIDTH-1:0];
        sat_o   = 1'b0;
        if (shifted > EXT_W'(SAMPLE_MAX)) begin
            data_o = SAMPLE_MAX;
            sat_o  = 1'b1;
        end else if (shifted < EXT_W'(SAMPLE_MIN)) begin
            data_o = SAMPLE_MIN;
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/rrc_mac_seq.sv
// rrc_mac_seq
//   Sequencer for a NUM_TAPS root-raised-cosine FIR that time-shares one
//   external multiplier-accumulator. Per accepted input sample it walks the
//   delay line newest-first, one tap per cycle, then waits for the MAC result,
//   rounds/clips it and presents it on the output handshake.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : slave side of rrc_mac_seq_if (samples, ROM/MAC drive, result)
//   dbg_state_o : current FSM state for observation
module rrc_mac_seq
    import gdsp_pkg::sample_t;
    import gdsp_pkg::accum_t;
#(
    parameter int NUM_TAPS    = gdsp_pkg::NUM_TAPS,
    parameter int DATA_WIDTH  = gdsp_pkg::DATA_WIDTH,
    parameter int ACCUM_WIDTH = gdsp_pkg::ACCUM_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    rrc_mac_seq_if.slave       bus,
    output logic [2:0]         dbg_state_o
);

    localparam int ADDR_W = gdsp_pkg::COEFF_ADDR_WIDTH;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_MAC      = 3'd1;
    localparam logic [2:0] ST_DRAIN    = 3'd2;
    localparam logic [2:0] ST_WAIT_ACC = 3'd3;
    localparam logic [2:0] ST_OUT      = 3'd4;

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(NUM_TAPS - 1);
    localparam logic [ADDR_W-1:0] TAPS_A = ADDR_W'(NUM_TAPS);

    logic [2:0]                   state_q,  state_d;
    logic [ADDR_W-1:0]            k_q,      k_d;
    logic [ADDR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic signed [DATA_WIDTH-1:0] dl_q [NUM_TAPS];
    logic [ADDR_W-1:0]            rd_idx;
    logic                         dl_we;
    logic                         res_load;

    sample_t                      mul_a_q;
    logic                         mac_en_q;
    logic                         mac_first_q;
    logic                         mac_last_q;
    sample_t                      out_data_q;
    logic                         out_sat_q;

    logic signed [ACCUM_WIDTH-1:0] acc_in;
    sample_t                       rs_data;
    logic                          rs_sat;

    assign acc_in = bus.acc_data;

    rrc_round_sat u_round_sat (
        .acc_i  (accum_t'(acc_in)),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    // Tap k reads the sample written k inputs ago: (wr_ptr - k) mod NUM_TAPS.
    // The true result is always below NUM_TAPS, so modular ADDR_W arithmetic
    // in the wrap branch gives the exact index.
    always_comb begin
        if (k_q <= wr_ptr_q) begin
            rd_idx = wr_ptr_q - k_q;
        end else begin
            rd_idx = wr_ptr_q + TAPS_A - k_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        wr_ptr_d = wr_ptr_q;
        dl_we    = 1'b0;
        res_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    dl_we   = 1'b1;
                    k_d     = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            // The strobes for the last tap are still in their register here.
            ST_DRAIN: state_d = ST_WAIT_ACC;
            ST_WAIT_ACC: begin
                if (bus.acc_valid) begin
                    res_load = 1'b1;
                    state_d  = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    // The pointer only advances once the output is consumed,
                    // so the next input overwrites the oldest sample.
                    wr_ptr_d = (wr_ptr_q == K_LAST) ? '0 : wr_ptr_q + 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            wr_ptr_q    <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                dl_q[i] <= '0;
            end
            mul_a_q     <= '0;
            mac_en_q    <= 1'b0;
            mac_first_q <= 1'b0;
            mac_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            wr_ptr_q <= wr_ptr_d;
            if (dl_we) begin
                dl_q[wr_ptr_q] <= bus.in_sample;
            end
            // Registered one cycle after coeff_addr to line up with ROM data.
            mac_en_q    <= (state_q == ST_MAC);
            mac_first_q <= (state_q == ST_MAC) && (k_q == '0);
            mac_last_q  <= (state_q == ST_MAC) && (k_q == K_LAST);
            mul_a_q     <= (state_q == ST_MAC) ? dl_q[rd_idx] : '0;
            if (res_load) begin
                out_data_q <= rs_data;
                out_sat_q  <= rs_sat;
            end
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.out_valid  = (state_q == ST_OUT);
    assign bus.coeff_addr = (state_q == ST_MAC) ? k_q : '0;
    assign bus.mul_a      = mul_a_q;
    assign bus.mac_en     = mac_en_q;
    assign bus.mac_first  = mac_first_q;
    assign bus.mac_last   = mac_last_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_sat    = out_sat_q;
    assign dbg_state_o    = state_q;

endmodule
